// File: rtl/foo_res_drain_if.sv
// Valid/ready result stream leaving the drain FIFO.
// master drives head data/valid, slave drives ready.
interface foo_res_drain_if #(
  parameter int width = 32
);
  logic [width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/foo_res_drain.sv
// Drain stage for the foo pipeline: FWFT FIFO turning the valid-only result stream into
// valid/ready, plus an in-flight tracker that grants upstream issue credit.
module foo_res_drain #(
  parameter int width = 32,
  parameter int depth = 8,
  parameter int lat   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [width-1:0]           res_in,
  input  logic                       res_vld_in,
  input  logic                       arg_issue,
  output logic                       arg_ok,
  foo_res_drain_if.master            dout,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow
);
  localparam int pw = (depth > 1) ? $clog2(depth) : 1;
  localparam int cw = $clog2(depth+1);
  localparam int iw = $clog2(depth+lat+1);

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr, rd_ptr;
  logic [iw-1:0]    inflight;
  logic             empty, full, push, pop, drop;
  logic [iw:0]      credit_sum;

  // Occupancy alone decides full/empty; pointers are free-running mod depth.
  assign empty = (count == '0);
  assign full  = (count == cw'(depth));

  assign dout.out_valid = !empty;
  assign dout.out_data  = empty ? '0 : mem[rd_ptr];

  assign pop  = dout.out_valid & dout.out_ready;
  assign push = res_vld_in & (!full | pop);
  assign drop = res_vld_in & full & !pop;

  // Credit looks only at registered state so upstream can use it without a comb loop.
  assign credit_sum = {1'b0, inflight} + (iw+1)'(count);
  assign arg_ok     = (credit_sum < (iw+1)'(depth));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;

      // A returning result moves its slot from in-flight into the FIFO, so the sum holds.
      case ({arg_issue, res_vld_in})
        2'b10:   if (inflight != '1) inflight <= inflight + 1'b1;
        2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_in;
  end
endmodule

// File: tb/tb_foo_res_drain.sv
// Directed bench for foo_res_drain: reset, fill/drain, full+pop, overflow, credit loop, wrap.
module tb_foo_res_drain;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  res_in = '0;
  logic          res_vld_in = 1'b0;
  logic          arg_issue = 1'b0;
  logic          arg_ok;
  logic [3:0]    count;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  foo_res_drain_if #(.width(W)) dout_if ();

  foo_res_drain #(.width(W), .depth(D), .lat(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_in     (res_in),
    .res_vld_in (res_vld_in),
    .arg_issue  (arg_issue),
    .arg_ok     (arg_ok),
    .dout       (dout_if),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [31:0] v);
    res_in     = v;
    res_vld_in = 1'b1;
    step();
    res_vld_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q[$];
    logic        pv [LAT];
    logic [31:0] pd [LAT];
    int          seq, npop, nxt, got;
    logic        issue, prev_hold;
    logic [31:0] prev_data;

    dout_if.out_ready = 1'b0;
    step();
    chk("rst_count", count, 0);
    chk("rst_valid", dout_if.out_valid, 0);
    chk("rst_data", dout_if.out_data, 0);
    chk("rst_argok", arg_ok, 1);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    step();

    // Fill with -1..-8 then drain in order
    for (int k = 1; k <= 8; k++) push_val(32'(-k));
    chk("fill_count", count, 8);
    chk("fill_argok", arg_ok, 0);
    chk("fill_valid", dout_if.out_valid, 1);
    dout_if.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_valid", dout_if.out_valid, 1);
      chk("drain_data", dout_if.out_data, 32'(-k));
      step();
    end
    chk("drain_empty", dout_if.out_valid, 0);
    chk("drain_zero", dout_if.out_data, 0);
    dout_if.out_ready = 1'b0;

    // Full with simultaneous push and pop
    for (int k = 0; k < 8; k++) push_val(32'(10 + k));
    chk("full_count", count, 8);
    dout_if.out_ready = 1'b1;
    res_in = 32'd100;
    res_vld_in = 1'b1;
    chk("full_head", dout_if.out_data, 10);
    step();
    res_vld_in = 1'b0;
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    for (int k = 1; k < 8; k++) begin
      chk("pp_data", dout_if.out_data, 32'(10 + k));
      step();
    end
    chk("pp_last", dout_if.out_data, 100);
    step();
    chk("pp_empty", dout_if.out_valid, 0);
    dout_if.out_ready = 1'b0;

    // Overflow: push into full FIFO without pop
    for (int k = 0; k < 8; k++) push_val(32'(20 + k));
    push_val(32'd99);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    dout_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_data", dout_if.out_data, 32'(20 + k));
      step();
    end
    chk("ovf_empty", dout_if.out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    dout_if.out_ready = 1'b0;

    // Mid-stream reset with count=5 and three args in flight
    for (int k = 0; k < 5; k++) push_val(32'(50 + k));
    arg_issue = 1'b1;
    step(); step(); step();
    arg_issue = 1'b0;
    chk("mid_count", count, 5);
    chk("mid_argok", arg_ok, 0);
    rst = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", dout_if.out_valid, 0);
    step();
    chk("mrst_count", count, 0);
    chk("mrst_valid", dout_if.out_valid, 0);
    chk("mrst_argok", arg_ok, 1);
    chk("mrst_ovf", overflow, 0);
    rst = 1'b1;
    step();

    // Credit: 7 issues keep arg_ok, 8th drops it
    for (int k = 1; k <= 7; k++) begin
      arg_issue = 1'b1;
      step();
      chk("cred_ok", arg_ok, 1);
    end
    step();
    arg_issue = 1'b0;
    chk("cred_full", arg_ok, 0);
    push_val(32'd1);
    chk("cred_res", arg_ok, 0);
    dout_if.out_ready = 1'b1;
    step();
    chk("cred_pop", arg_ok, 1);
    for (int k = 0; k < 7; k++) push_val(32'(2 + k));
    step();
    chk("cred_idle_cnt", count, 0);

    // Closed loop with a foo latency model and random backpressure
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    seq = 0; npop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      res_vld_in = pv[LAT-1];
      res_in     = pd[LAT-1];
      if (pv[LAT-1]) exp_q.push_back(pd[LAT-1]);
      issue = (cyc < 300) && arg_ok && ($urandom_range(0, 3) != 0);
      arg_issue = issue;
      dout_if.out_ready = 1'($urandom_range(0, 1));
      if (dout_if.out_valid && dout_if.out_ready) begin
        if (exp_q.size() == 0) chk("loop_extra", 1, 0);
        else begin
          chk("loop_data", dout_if.out_data, exp_q.pop_front());
          npop++;
        end
      end
      for (int i = LAT-1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = issue;
      pd[0] = 32'(seq);
      if (issue) seq++;
      step();
    end
    res_vld_in = 1'b0;
    arg_issue  = 1'b0;
    chk("loop_ovf", overflow, 0);
    chk("loop_popped", npop, seq);
    chk("loop_left", exp_q.size(), 0);
    chk("loop_count", count, 0);

    // Wrap-around with ramp data and head-stability check
    nxt = 0; got = 0; prev_hold = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      res_vld_in = (nxt < 20) && arg_ok;
      res_in     = 32'(nxt);
      if (res_vld_in) nxt++;
      dout_if.out_ready = 1'($urandom_range(0, 1));
      if (prev_hold) begin
        chk("hold_valid", dout_if.out_valid, 1);
        chk("hold_data", dout_if.out_data, prev_data);
      end
      if (dout_if.out_valid && dout_if.out_ready) begin
        chk("wrap_data", dout_if.out_data, 32'(got));
        got++;
      end
      prev_hold = dout_if.out_valid && !dout_if.out_ready;
      prev_data = dout_if.out_data;
      step();
    end
    res_vld_in = 1'b0;
    chk("wrap_cnt", got, 20);
    chk("wrap_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
